note_tracker: RTL

//  Downstream of noteIdentification. Consumes its raw per-window note code (note, readVal strobe).

---
 rtl/note_pkg.sv | 16 +
 rtl/sat_counter.sv | 37 +++
 rtl/note_tracker.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/note_pkg.sv
// ---------------------------------------------------------------------------
// note_pkg
// Shared definitions for the note tracking path: note code width, the
// silence code and the default number of valid note codes produced by
// noteIdentification.
// ---------------------------------------------------------------------------
package note_pkg;

    localparam int NOTE_W = 4;
    typedef logic [NOTE_W-1:0] note_t;

    // Code 0 is silence; valid notes are 1..NUM_NOTES.
    localparam note_t NOTE_NONE = 4'd0;
    localparam int    NUM_NOTES = 12;

endpackage : note_pkg

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that saturates at MAX.
// Ports:
//   clk    in  1  clock
//   reset  in  1  asynchronous active-low reset (count -> 0)
//   clr    in  1  restart the count; with inc also high the count restarts at 1
//   set    in  1  load MAX (lower priority than clr)
//   inc    in  1  increment by one, holding at MAX
//   count  out W  current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         set,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            // clr+inc means "this event is the first one of a new run".
            count <= inc ? W'(1) : '0;
        end else if (set) begin
            count <= MAX;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/note_tracker.sv
// ---------------------------------------------------------------------------
// note_tracker
// Debounces the raw per-window note codes from noteIdentification into a
// stable played note, emits single-cycle note_start / note_end events and
// measures how long each note is held. A watchdog forces silence when the
// identifier stops strobing readVal.
// Ports:
//   clk           in   1      system clock
//   reset         in   1      asynchronous active-low reset
//   note          in   4      raw note code (valid when readVal=1)
//   readVal       in   1      single-cycle strobe qualifying note
//   stable_note   out  4      committed note code, 0 = silence
//   note_valid    out  1      stable_note != 0
//   note_start    out  1      pulse: a nonzero note was committed
//   note_end      out  1      pulse: the previous nonzero note was released
//   held_cycles   out  DUR_W  cycles since the current note_start (saturating)
//   end_duration  out  DUR_W  held_cycles of the note released with note_end
// ---------------------------------------------------------------------------
module note_tracker #(
    parameter int STABLE_COUNT   = 3,
    parameter int NUM_NOTES      = note_pkg::NUM_NOTES,
    parameter int TIMEOUT_CYCLES = 1 << 20,
    parameter int DUR_W          = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  note_pkg::note_t     note,
    input  logic                readVal,
    output note_pkg::note_t     stable_note,
    output logic                note_valid,
    output logic                note_start,
    output logic                note_end,
    output logic [DUR_W-1:0]    held_cycles,
    output logic [DUR_W-1:0]    end_duration
);

    import note_pkg::*;

    localparam int               CNT_W   = 4;
    localparam logic [CNT_W-1:0] SC      = CNT_W'(STABLE_COUNT);
    localparam int               WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    // Out-of-range codes are treated as silence.
    function automatic note_t sanitize(input note_t code);
        if ((code == NOTE_NONE) || (code > NOTE_W'(NUM_NOTES)))
            return NOTE_NONE;
        return code;
    endfunction

    note_t             s_note;
    note_t             cand_note;
    note_t             commit_note;
    logic [CNT_W-1:0]  cand_cnt;
    logic [CNT_W-1:0]  cand_cnt_next;
    logic [WD_W-1:0]   wd_cnt;
    logic              cand_match;
    logic              rd_commit;
    logic              timeout;
    logic              commit_en;
    logic              stable_silent;

    always_comb begin
        s_note        = sanitize(note);
        cand_match    = (s_note == cand_note);
        stable_silent = (stable_note == NOTE_NONE);

        // Candidate count as it will be after this readVal.
        if (!cand_match)
            cand_cnt_next = CNT_W'(1);
        else if (cand_cnt == SC)
            cand_cnt_next = SC;
        else
            cand_cnt_next = cand_cnt + CNT_W'(1);

        // Re-reading the already committed note never re-commits.
        rd_commit = readVal && (cand_cnt_next == SC) && (s_note != stable_note);

        // A strobe in the last watchdog cycle is processed normally instead.
        timeout   = !readVal && (wd_cnt == WD_LAST);

        commit_en   = rd_commit || (timeout && !stable_silent);
        commit_note = rd_commit ? s_note : NOTE_NONE;
    end

    // Candidate run length; a timeout parks it at STABLE_COUNT on silence so
    // further silence readings are treated as repeats.
    sat_counter #(.W(CNT_W), .MAX(SC)) u_cand_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (readVal && !cand_match),
        .set   (timeout),
        .inc   (readVal),
        .count (cand_cnt)
    );

    // Hold duration: restarts on every commit and stays 0 during silence.
    sat_counter #(.W(DUR_W)) u_held (
        .clk   (clk),
        .reset (reset),
        .clr   (commit_en || stable_silent),
        .set   (1'b0),
        .inc   (!stable_silent && !commit_en),
        .count (held_cycles)
    );

    // Reading watchdog: cycles since the last readVal.
    sat_counter #(.W(WD_W)) u_wd (
        .clk   (clk),
        .reset (reset),
        .clr   (readVal || timeout),
        .set   (1'b0),
        .inc   (!(readVal || timeout)),
        .count (wd_cnt)
    );

    // Registered commit stage: stable note and event pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand_note    <= NOTE_NONE;
            stable_note  <= NOTE_NONE;
            note_valid   <= 1'b0;
            note_start   <= 1'b0;
            note_end     <= 1'b0;
            end_duration <= '0;
        end else begin
            note_start <= 1'b0;
            note_end   <= 1'b0;

            if (readVal)
                cand_note <= s_note;
            else if (timeout)
                cand_note <= NOTE_NONE;

            if (commit_en) begin
                stable_note <= commit_note;
                note_valid  <= (commit_note != NOTE_NONE);
                note_start  <= (commit_note != NOTE_NONE);
                if (!stable_silent) begin
                    note_end     <= 1'b1;
                    end_duration <= held_cycles;
                end
            end
        end
    end

endmodule : note_tracker
